toggle_handshake_rx: RTL
========================

Name: toggle_handshake_rx

Overview:
- Receiving end of a two-phase (toggle) request/acknowledge crossing.
- The sending domain flips a request level with a T-type toggle and holds a data word stable.
- This block synchronizes the request level and detects the level change.
- It captures the word, presents it on a valid/ready interface in the local clk domain, and returns completion by flipping its own acknowledge level.

Parameters:
- DATA_W, 8, width of the transferred data word.
- SYNC_STAGES, 2, flops in the request synchronizer chain. Legal minimum is 2; elaboration fails below 2.
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  input  1  local clock.
- rst  input  1  reset, asynchronous, active-high.
- req_tgl_in  input  1  request level from the sender domain, asynchronous to clk. Each level change is one transfer.
- data_in  input  DATA_W  sender data. Stable from its request toggle until the matching ack toggle is seen.
- out_valid  output  1  captured word available.
- out_data  output  DATA_W  captured word.
- out_ready  input  1  consumer accepts the word when out_valid is high.
- ack_tgl_out  output  1  acknowledge level. Flips once per completed transfer.
- overrun  output  1  sticky protocol-error flag.
- xfer_count  output  CNT_W  completed transfers; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release): sync chain, req_seen, out_valid, out_data, ack_tgl_out, overrun and xfer_count all go to 0; FSM goes to IDLE.
- Synchronizer: req_tgl_in passes through SYNC_STAGES flops; req_s is the last stage.
- Edge detect: edge = (req_s != req_seen). req_seen holds the last accepted request level.
- FSM states: IDLE, HOLD.
- IDLE, edge=1:
  - out_data <= data_in, req_seen <= req_s, out_valid <= 1, next state HOLD.
  - Latency: request change to out_valid high = SYNC_STAGES+1 rising clk edges, worst case plus one for metastability resolution.
- IDLE, edge=0: hold all outputs; out_valid=0.
- HOLD, out_ready=0:
  - out_valid stays 1; out_data stays stable; ack_tgl_out does not change.
- HOLD, out_ready=1 (handshake):
  - On that edge: out_valid <= 0, ack_tgl_out <= ~ack_tgl_out, xfer_count <= xfer_count+1, next state IDLE.
  - ack_tgl_out is a flop output, never combinational.
- HOLD, edge=1 (sender toggled again before seeing ack):
  - overrun <= 1. overrun is sticky and cleared only by rst.
  - The current word is not disturbed.
  - The pending edge stays visible because req_seen is not updated, and it is accepted in IDLE after the handshake.
  - If the sender toggles twice and returns req to the accepted level, the edge vanishes and no extra transfer occurs; overrun stays 1 if it was set.
- Back-to-back transfers: at least one IDLE cycle between consecutive out_valid pulses. out_valid is low for exactly one cycle when an edge is already pending.
- Both polarities of request change (0->1 and 1->0) are equal transfers.
- xfer_count wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-HOLD: out_valid drops immediately (async) and the word is lost. Sender and receiver share rst, so both levels restart at 0; a sender holding req=1 across a lone receiver reset produces one spurious transfer, which is legal.
- No combinational path from req_tgl_in or data_in to any output.
- data_in is sampled only in the capture cycle, relying on the sender's hold guarantee. data_in is not synchronized.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, HOLD).
  - Constant SYNC_STAGES_MIN = 2.
  - The package is reused by the sender-side toggle block.
- One sub-module: sync_bit_n (parameterized N-stage single-bit synchronizer with async active-high reset to 0).
- Top-level holds the edge detect, FSM, capture register, ack flop and counter.

Test Plan:
- Reset: hold rst=1 with req_tgl_in toggling -> out_valid=0, ack_tgl_out=0, overrun=0, xfer_count=0 throughout.
- Single transfer (SYNC_STAGES=2): data_in=0xA5, req 0->1 at cycle 0, out_ready=1 -> out_valid=1 exactly at cycle 3 for one cycle, out_data=0xA5, ack_tgl_out=1 at cycle 4, xfer_count=1.
- Backpressure: second transfer data_in=0x3C, req 1->0, out_ready=0 for 5 cycles -> out_valid stays 1 with out_data=0x3C and ack unchanged. Then raise out_ready -> ack_tgl_out=0 next edge, xfer_count=2.
- Overrun: while in HOLD with out_ready=0, toggle req again with data_in=0x55 -> overrun=1 within SYNC_STAGES+1 cycles. After the handshake, out_valid low one cycle, then 0x55 delivered; overrun stays 1.
- Counter wrap (CNT_W=4): 16 complete transfers -> xfer_count returns to 0, ack_tgl_out=0, overrun=0.
- Reset mid-HOLD: assert rst with out_valid=1 -> out_valid and ack_tgl_out go to 0 asynchronously. After release with req=0, no transfer occurs.

Source files
------------

// File: rtl/toggle_handshake_rx_pkg.sv
// Shared definitions for both ends of the two-phase (toggle) request/ack crossing.
package toggle_handshake_rx_pkg;

  // Receiver handshake state: waiting for a request edge, or holding a captured word.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Fewest synchronizer flops that give the request level a chance to settle.
  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/toggle_handshake_rx_sync_bit_n.sv
// N-stage single-bit synchronizer; every stage resets to 0.
module sync_bit_n #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of the previous one.
    if (rst) chain <= '0;
    else     chain <= {chain[N-2:0], d};
  end

  assign q = chain[N-1];

endmodule

// File: rtl/toggle_handshake_rx.sv
// Receiving end of a two-phase toggle handshake: synchronizes the request level,
// captures the sender's word on a level change, presents it on valid/ready and
// returns completion by flipping the acknowledge level.
module toggle_handshake_rx
  import toggle_handshake_rx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_tgl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              ack_tgl_out,
  output logic              overrun,
  output logic [CNT_W-1:0]  xfer_count
);

  // A single flop cannot be trusted to resolve metastability; refuse to build.
  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync_stages
    $error("toggle_handshake_rx: SYNC_STAGES must be at least 2");
  end

  state_t state;
  logic   req_s;
  logic   req_seen;
  logic   req_edge;

  sync_bit_n #(
    .N (SYNC_STAGES)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req_tgl_in),
    .q   (req_s)
  );

  // A pending transfer is any difference between the synchronized level and the last accepted one.
  assign req_edge = (req_s != req_seen);

  // Handshake FSM with capture register, ack flop, overrun flag and transfer counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_seen    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      ack_tgl_out <= 1'b0;
      overrun     <= 1'b0;
      xfer_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_edge) begin
            // data_in is held stable by the sender until it sees our ack, so no sync is needed.
            out_data  <= data_in;
            req_seen  <= req_s;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            out_valid <= 1'b0;
          end
        end
        HOLD: begin
          // A new edge while holding means the sender ignored the ack; leave req_seen
          // alone so the edge is still pending once this word is consumed.
          if (req_edge) overrun <= 1'b1;
          if (out_ready) begin
            out_valid   <= 1'b0;
            ack_tgl_out <= ~ack_tgl_out;
            xfer_count  <= xfer_count + CNT_W'(1);
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
